// File: rtl/ysyx_25030085_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction in flight at a time; a stalled response is answered with an error pulse.
//
// state  | meaning
// S_IDLE | no transaction in flight, grant offered to requesters
// S_REQ  | latched request presented downstream, waiting for mem_req_ready
// S_RESP | waiting for mem_rsp_valid, timer counting toward TIMEOUT
module ysyx_25030085_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MW = DATA_W / 8;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_last_lsu;
   logic            r_owner_lsu;
   logic [TW-1:0]   r_timer;
   logic            w_grant_lsu;
   logic            w_accept;
   logic            w_rsp_ok;
   logic            w_rsp_to;

   // LSU wins a tie unless it was the previous grant
   assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | ~r_last_lsu);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      w_accept      = 1'b0;
      w_rsp_ok      = 1'b0;
      w_rsp_to      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!rst) begin
               ifu_req_ready = ifu_req_valid & ~w_grant_lsu;
               lsu_req_ready = w_grant_lsu;
               w_accept      = ifu_req_valid | lsu_req_valid;
            end
            if (w_accept) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (mem_rsp_valid) begin
               w_rsp_ok    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_rsp_to    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_lsu  <= 1'b0;
         r_owner_lsu <= 1'b0;
         mem_addr    <= '0;
         mem_wen     <= 1'b0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
      end else if (w_accept) begin
         r_owner_lsu <= w_grant_lsu;
         r_last_lsu  <= w_grant_lsu;
         if (w_grant_lsu) begin
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wen ? lsu_wdata : '0;
            mem_wmask <= lsu_wen ? lsu_wmask : MW'(0);
         end else begin
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                    r_timer <= '0;
      else if (r_state == S_REQ)  r_timer <= '0;
      else if (r_state == S_RESP) r_timer <= r_timer + TW'(1);
   end

   // Response pulses last one cycle; read data holds until that port's next response
   always_ff @(posedge clk) begin
      if (rst) begin
         ifu_rsp_valid <= 1'b0;
         ifu_rsp_err   <= 1'b0;
         ifu_rdata     <= '0;
         lsu_rsp_valid <= 1'b0;
         lsu_rsp_err   <= 1'b0;
         lsu_rdata     <= '0;
      end else begin
         ifu_rsp_valid <= 1'b0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rsp_err   <= 1'b0;
         if (w_rsp_ok | w_rsp_to) begin
            if (r_owner_lsu) begin
               lsu_rsp_valid <= 1'b1;
               lsu_rsp_err   <= w_rsp_to;
               lsu_rdata     <= (w_rsp_ok & ~mem_wen) ? mem_rdata : '0;
            end else begin
               ifu_rsp_valid <= 1'b1;
               ifu_rsp_err   <= w_rsp_to;
               ifu_rdata     <= w_rsp_ok ? mem_rdata : '0;
            end
         end
      end
   end

endmodule
